// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// One operation in flight; operands held EXEC_CYCLES cycles, result returned on valid/ready.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_last_bit,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_last_bit,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_last_bit,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic        grant;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] res_q;
    logic        zero_q;
    logic        last_bit_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic        busy_q;
    logic        acc0;
    logic        acc1;
    logic        rsp_hs;

    // On a tie the requester not served last wins.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && (state == IDLE) && !grant && req0_valid;
    assign req1_ready = !rst && (state == IDLE) && grant && req1_valid;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign rsp_hs     = (rsp0_valid_q && rsp0_ready) ||
                        (rsp1_valid_q && rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= 4'd0;
            op_q         <= 4'd0;
            src1_q       <= 32'd0;
            src2_q       <= 32'd0;
            res_q        <= 32'd0;
            zero_q       <= 1'b0;
            last_bit_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        op_q   <= acc1 ? req1_op : req0_op;
                        src1_q <= acc1 ? req1_src1 : req0_src1;
                        src2_q <= acc1 ? req1_src2 : req0_src2;
                        owner  <= acc1;
                        cnt    <= CNT_INIT;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_q        <= alu_result;
                        zero_q       <= alu_zero;
                        last_bit_q   <= alu_last_bit;
                        rsp0_valid_q <= !owner;
                        rsp1_valid_q <= owner;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        last_grant   <= owner;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_control   = op_q;
    assign alu_src1      = src1_q;
    assign alu_src2      = src2_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_result   = res_q;
    assign rsp1_result   = res_q;
    assign rsp0_zero     = zero_q;
    assign rsp1_zero     = zero_q;
    assign rsp0_last_bit = last_bit_q;
    assign rsp1_last_bit = last_bit_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: two instances (EXEC_CYCLES 1 and 3),
// each driven by a behavioural ALU; expected results are hand-computed.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    typedef struct packed {
        logic        own;
        logic [31:0] r;
    } exp_t;

    logic        clk;
    logic        rst    [2];
    logic        rq_v   [2][2];
    logic        rq_r   [2][2];
    logic [3:0]  rq_op  [2][2];
    logic [31:0] rq_a   [2][2];
    logic [31:0] rq_b   [2][2];
    logic        rs_v   [2][2];
    logic        rs_r   [2][2];
    logic [31:0] rs_res [2][2];
    logic        rs_z   [2][2];
    logic        rs_lb  [2][2];
    logic [3:0]  actl   [2];
    logic [31:0] as1    [2];
    logic [31:0] as2    [2];
    logic [31:0] ares   [2];
    logic        az     [2];
    logic        alb    [2];
    logic        busy   [2];

    exp_t sb0[$];
    exp_t sb1[$];
    int   acc_log[$];
    int   tests;
    int   fails;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ares[g] = alu_f(actl[g], as1[g], as2[g]);
        assign az[g]   = (ares[g] == 32'd0);
        assign alb[g]  = ares[g][0];

        alu_arbiter #(.EXEC_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .req0_valid   (rq_v[g][0]),
            .req0_ready   (rq_r[g][0]),
            .req0_op      (rq_op[g][0]),
            .req0_src1    (rq_a[g][0]),
            .req0_src2    (rq_b[g][0]),
            .rsp0_valid   (rs_v[g][0]),
            .rsp0_ready   (rs_r[g][0]),
            .rsp0_result  (rs_res[g][0]),
            .rsp0_zero    (rs_z[g][0]),
            .rsp0_last_bit(rs_lb[g][0]),
            .req1_valid   (rq_v[g][1]),
            .req1_ready   (rq_r[g][1]),
            .req1_op      (rq_op[g][1]),
            .req1_src1    (rq_a[g][1]),
            .req1_src2    (rq_b[g][1]),
            .rsp1_valid   (rs_v[g][1]),
            .rsp1_ready   (rs_r[g][1]),
            .rsp1_result  (rs_res[g][1]),
            .rsp1_zero    (rs_z[g][1]),
            .rsp1_last_bit(rs_lb[g][1]),
            .alu_control  (actl[g]),
            .alu_src1     (as1[g]),
            .alu_src2     (as2[g]),
            .alu_result   (ares[g]),
            .alu_zero     (az[g]),
            .alu_last_bit (alb[g]),
            .busy         (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rsp_pop(input int d, input int n);
        exp_t e;
        int   sz;
        sz = (d == 0) ? sb0.size() : sb1.size();
        tests++;
        if (sz == 0) begin
            fails++;
            $display("FAIL unexpected_rsp: dut%0d port%0d result %h expected none",
                     d, n, rs_res[d][n]);
            return;
        end
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("rsp_owner d%0d", d), n, {31'd0, e.own});
        chk($sformatf("rsp_result d%0d", d), rs_res[d][n], e.r);
        chk($sformatf("rsp_zero d%0d", d), rs_z[d][n], e.r == 32'd0);
        chk($sformatf("rsp_last_bit d%0d", d), rs_lb[d][n], e.r[0]);
    endtask

    // Monitor: compares each response handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst[d]) begin
                    if (rs_v[d][0] && rs_v[d][1]) begin
                        chk("rsp_valid_onehot", 32'd2, 32'd1);
                    end
                    for (int n = 0; n < 2; n++) begin
                        if (rs_v[d][n] && rs_r[d][n]) rsp_pop(d, n);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input int n, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, output int waited);
        exp_t e;
        int   i;
        rq_op[d][n] = op;
        rq_a[d][n]  = a;
        rq_b[d][n]  = b;
        rq_v[d][n]  = 1'b1;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rq_r[d][n]) break;
        end
        waited = i;
        if (i == 100) begin
            chk($sformatf("req_timeout d%0d n%0d", d, n), 32'd0, 32'd1);
        end else begin
            e.own = n[0];
            e.r   = r;
            if (d == 0) sb0.push_back(e);
            else sb1.push_back(e);
            acc_log.push_back(n);
        end
        @(posedge clk);
        #1;
        rq_v[d][n] = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        for (int n = 0; n < 2; n++) begin
            chk({tag, "_req_ready"}, rq_r[d][n], 32'd0);
            chk({tag, "_rsp_valid"}, rs_v[d][n], 32'd0);
            chk({tag, "_rsp_result"}, rs_res[d][n], 32'd0);
            chk({tag, "_rsp_zero"}, rs_z[d][n], 32'd0);
            chk({tag, "_rsp_last_bit"}, rs_lb[d][n], 32'd0);
        end
        chk({tag, "_alu_control"}, actl[d], 32'd0);
        chk({tag, "_alu_src1"}, as1[d], 32'd0);
        chk({tag, "_alu_src2"}, as2[d], 32'd0);
        chk({tag, "_busy"}, busy[d], 32'd0);
    endtask

    task automatic do_reset(input int d, input string tag);
        rst[d] = 1'b1;
        if (d == 0) sb0.delete();
        else sb1.delete();
        @(posedge clk);
        #1;
        chk_zero(d, tag);
        rst[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy[d] && ((d == 0) ? sb0.size() : sb1.size()) == 0) break;
        end
        if (i == 200) chk($sformatf("drain_timeout d%0d", d), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int w1;
        tests = 0;
        fails = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            for (int n = 0; n < 2; n++) begin
                rq_v[d][n]  = 1'b0;
                rq_op[d][n] = 4'd0;
                rq_a[d][n]  = 32'd0;
                rq_b[d][n]  = 32'd0;
                rs_r[d][n]  = 1'b1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // 1: single op, latency and busy
        issue(0, 0, ALU_ADD, 32'd5, 32'd3, 32'd8, w);
        chk("t1_ready_same_cycle", w, 32'd0);
        chk("t1_busy_exec", busy[0], 32'd1);
        chk("t1_no_rsp_yet", rs_v[0][0], 32'd0);
        @(posedge clk);
        #1;
        chk("t1_rsp0_valid", rs_v[0][0], 32'd1);
        chk("t1_rsp1_quiet", rs_v[0][1], 32'd0);
        chk("t1_busy_resp", busy[0], 32'd1);
        @(posedge clk);
        #1;
        chk("t1_busy_idle", busy[0], 32'd0);
        drain(0);

        // 2: ties after reset, then a second tie goes to req1
        do_reset(0, "t2_reset");
        acc_log.delete();
        fork
            begin
                issue(0, 0, ALU_SUB, 32'd7, 32'd7, 32'd0, w);
                issue(0, 0, ALU_AND, 32'h0000FF00, 32'h00000FF0,
                      32'h00000F00, w);
            end
            issue(0, 1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, w1);
        join
        drain(0);
        chk("t2_log_size", acc_log.size(), 32'd3);
        if (acc_log.size() == 3) begin
            chk("t2_first_req0", acc_log[0], 32'd0);
            chk("t2_second_tie_req1", acc_log[1], 32'd1);
            chk("t2_third_req0", acc_log[2], 32'd0);
        end

        // 3: backpressure on rsp0 with req1 pending
        rs_r[0][0] = 1'b0;
        issue(0, 0, ALU_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, w);
        fork
            issue(0, 1, ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, w1);
            begin
                @(posedge clk);
                #1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("t3_rsp0_valid_hold", rs_v[0][0], 32'd1);
                    chk("t3_rsp0_result_hold", rs_res[0][0], 32'hF0F00F0F);
                    chk("t3_req1_blocked", rq_r[0][1], 32'd0);
                    chk("t3_busy", busy[0], 32'd1);
                end
                @(posedge clk);
                #1;
                rs_r[0][0] = 1'b1;
                @(posedge clk);
                #1;
                chk("t3_idle_after_hs", busy[0], 32'd0);
                chk("t3_req1_ready_idle", rq_r[0][1], 32'd1);
            end
        join
        drain(0);

        // 4: EXEC_CYCLES=3 holds ALU inputs, response at T+4
        issue(1, 1, ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, w);
        for (int k = 0; k < 3; k++) begin
            chk("t4_alu_control", actl[1], ALU_SRA);
            chk("t4_alu_src1", as1[1], 32'h80000000);
            chk("t4_alu_src2", as2[1], 32'd4);
            chk("t4_no_rsp_yet", rs_v[1][1], 32'd0);
            @(posedge clk);
            #1;
        end
        chk("t4_rsp1_valid", rs_v[1][1], 32'd1);
        chk("t4_rsp0_quiet", rs_v[1][0], 32'd0);
        drain(1);

        // 5: reset mid-EXEC discards the op and restores req0 priority
        issue(0, 0, ALU_SLL, 32'd1, 32'd4, 32'd16, w);
        drain(0);
        issue(0, 0, ALU_ADD, 32'd1, 32'd1, 32'd2, w);
        chk("t5_in_exec", busy[0], 32'd1);
        do_reset(0, "t5_reset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5_no_rsp0", rs_v[0][0], 32'd0);
            chk("t5_no_rsp1", rs_v[0][1], 32'd0);
        end
        @(posedge clk);
        #1;
        acc_log.delete();
        fork
            issue(0, 0, ALU_AND, 32'hC, 32'hA, 32'h8, w);
            issue(0, 1, ALU_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, w1);
        join
        drain(0);
        chk("t5_log_size", acc_log.size(), 32'd2);
        if (acc_log.size() == 2) begin
            chk("t5_tie_req0", acc_log[0], 32'd0);
            chk("t5_then_req1", acc_log[1], 32'd1);
        end

        // 6: compares and an undefined op code
        issue(0, 0, ALU_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, w);
        issue(0, 0, ALU_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, w);
        issue(0, 0, 4'hF, 32'h12345678, 32'h9ABCDEF0, 32'd0, w);
        drain(0);
        issue(0, 1, ALU_SRL, 32'h80000000, 32'd31, 32'd1, w);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
